// File: rtl/sprite_compositor.sv
// Multi-sprite pixel compositor.
// It overlays up to NUM_SPRITES animated 1-bpp sprites on the background tile colour.
// Sprite registers are double-buffered and load on frame_start.
// Sprite 0 is checked for collisions against every other sprite.
// Pixel in at cycle t gives colour out at t+2. One pixel per cycle, no stalls.
module sprite_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_SIZE = 8,
  parameter int COORD_W     = 12,
  parameter int COLOR_W     = 12,
  parameter int ANIM_DIV    = 8,
  localparam int LW         = $clog2(SPRITE_SIZE)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               frame_start,
  input  logic                               video_on,
  input  logic [COORD_W-1:0]                 pixel_x,
  input  logic [COORD_W-1:0]                 pixel_y,
  input  logic [COLOR_W-1:0]                 tile_color,
  input  logic [NUM_SPRITES*COORD_W-1:0]     spr_x,
  input  logic [NUM_SPRITES*COORD_W-1:0]     spr_y,
  input  logic [NUM_SPRITES-1:0]             spr_en,
  input  logic [NUM_SPRITES*COLOR_W-1:0]     spr_color,
  output logic [NUM_SPRITES*LW-1:0]          spr_row_addr,
  input  logic [NUM_SPRITES*SPRITE_SIZE-1:0] rom_row_a,
  input  logic [NUM_SPRITES*SPRITE_SIZE-1:0] rom_row_b,
  output logic [COLOR_W-1:0]                 pixel_color_out,
  output logic                               video_on_out,
  output logic                               anim_phase,
  output logic                               collision,
  output logic [NUM_SPRITES-1:0]             collision_mask
);

  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ANIM_DIV - 1);
  // The bounds are one bit wider than the coordinates, so x+SIZE can never wrap past zero.
  localparam logic [COORD_W:0] SIZE_E = (COORD_W + 1)'(SPRITE_SIZE);
  // Mask that removes sprite 0 from the collision vector.
  localparam logic [NUM_SPRITES-1:0] NOT_PAC = ~(NUM_SPRITES'(1));

  // Active (frame-latched) sprite registers
  logic [NUM_SPRITES-1:0][COORD_W-1:0] act_x_q, act_x_d;
  logic [NUM_SPRITES-1:0][COORD_W-1:0] act_y_q, act_y_d;
  logic [NUM_SPRITES-1:0]              act_en_q, act_en_d;
  logic [NUM_SPRITES-1:0][COLOR_W-1:0] act_color_q, act_color_d;

  // Animation state
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             anim_phase_q, anim_phase_d;

  // Pipeline stage S1
  logic [NUM_SPRITES-1:0]          s1_hit_q, s1_hit_d;
  logic [NUM_SPRITES-1:0][LW-1:0]  s1_sx_q, s1_sx_d;
  logic [COLOR_W-1:0]              s1_tile_q, s1_tile_d;
  logic                            s1_vo_q, s1_vo_d;
  logic                            s1_phase_q, s1_phase_d;

  // Pipeline stage S2 and the output colour register
  logic [NUM_SPRITES-1:0] s2_opaque_q, s2_opaque_d;
  logic                   s2_vo_q, s2_vo_d;
  logic [COLOR_W-1:0]     pix_q, pix_d;

  // Sticky collision state
  logic [NUM_SPRITES-1:0] mask_q, mask_d;
  logic [NUM_SPRITES-1:0] set_bits;

  // Per-sprite combinational results
  logic [NUM_SPRITES-1:0]         hit_c;
  logic [NUM_SPRITES-1:0][LW-1:0] sx_c;
  logic [NUM_SPRITES-1:0]         opaque_c;

  // Shadow registers are copied into the active set only on frame_start
  always_comb begin
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    act_en_d    = act_en_q;
    act_color_d = act_color_q;
    if (frame_start) begin
      act_x_d     = spr_x;
      act_y_d     = spr_y;
      act_en_d    = spr_en;
      act_color_d = spr_color;
    end
  end

  // Count frames. The phase flips each time the counter wraps to zero.
  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    anim_phase_d = anim_phase_q;
    if (frame_start) begin
      if (frame_cnt_q == CNT_MAX) begin
        frame_cnt_d  = '0;
        anim_phase_d = ~anim_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Stage 0: bounding-box hit test, local column, and ROM row address for each sprite
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_stage0
      logic [COORD_W:0] px_e, py_e, x_e, y_e;
      logic             in_x, in_y;

      // Widen the coordinates so the upper bound compare stays exact at the screen edge
      always_comb begin
        px_e = {1'b0, pixel_x};
        py_e = {1'b0, pixel_y};
        x_e  = {1'b0, act_x_q[gi]};
        y_e  = {1'b0, act_y_q[gi]};
        in_x = (px_e >= x_e) && (px_e < x_e + SIZE_E);
        in_y = (py_e >= y_e) && (py_e < y_e + SIZE_E);
      end

      assign hit_c[gi] = act_en_q[gi] && in_x && in_y;
      // Only the low LW bits of the differences are needed, so subtract just those bits.
      assign sx_c[gi]  = pixel_x[LW-1:0] - act_x_q[gi][LW-1:0];
      assign spr_row_addr[gi*LW +: LW] = pixel_y[LW-1:0] - act_y_q[gi][LW-1:0];
    end
  endgenerate

  // Stage 1: select the ROM row for the captured phase, then test the column bit
  generate
    for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_stage1
      logic [SPRITE_SIZE-1:0] row;
      assign row = s1_phase_q ? rom_row_b[gi*SPRITE_SIZE +: SPRITE_SIZE]
                              : rom_row_a[gi*SPRITE_SIZE +: SPRITE_SIZE];
      // Bit 0 of the row is the leftmost pixel
      assign opaque_c[gi] = s1_hit_q[gi] & row[s1_sx_q[gi]];
    end
  endgenerate

  // Next-state values for the pipeline registers
  always_comb begin
    s1_hit_d    = hit_c;
    s1_sx_d     = sx_c;
    s1_tile_d   = tile_color;
    s1_vo_d     = video_on;
    s1_phase_d  = anim_phase_q;
    s2_opaque_d = opaque_c;
    s2_vo_d     = s1_vo_q;
  end

  // Priority mux: blank, else lowest-index opaque sprite, else background
  always_comb begin
    pix_d = '0;
    if (s1_vo_q) begin
      pix_d = s1_tile_q;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
        if (opaque_c[i]) begin
          pix_d = act_color_q[i];
        end
      end
    end
  end

  // Collision accumulation. A hit that arrives together with frame_start is kept.
  always_comb begin
    set_bits = '0;
    if (s2_vo_q && s2_opaque_q[0]) begin
      set_bits = s2_opaque_q & NOT_PAC;
    end
    mask_d = frame_start ? set_bits : (mask_q | set_bits);
  end

  // Active sprite register bank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_x_q     <= '0;
      act_y_q     <= '0;
      act_en_q    <= '0;
      act_color_q <= '0;
    end else begin
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      act_en_q    <= act_en_d;
      act_color_q <= act_color_d;
    end
  end

  // Animation counter and phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q  <= '0;
      anim_phase_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      anim_phase_q <= anim_phase_d;
    end
  end

  // Pixel pipeline registers. Reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_hit_q    <= '0;
      s1_sx_q     <= '0;
      s1_tile_q   <= '0;
      s1_vo_q     <= 1'b0;
      s1_phase_q  <= 1'b0;
      s2_opaque_q <= '0;
      s2_vo_q     <= 1'b0;
      pix_q       <= '0;
    end else begin
      s1_hit_q    <= s1_hit_d;
      s1_sx_q     <= s1_sx_d;
      s1_tile_q   <= s1_tile_d;
      s1_vo_q     <= s1_vo_d;
      s1_phase_q  <= s1_phase_d;
      s2_opaque_q <= s2_opaque_d;
      s2_vo_q     <= s2_vo_d;
      pix_q       <= pix_d;
    end
  end

  // Sticky collision mask
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign pixel_color_out = pix_q;
  assign video_on_out    = s2_vo_q;
  assign anim_phase      = anim_phase_q;
  assign collision_mask  = mask_q;
  assign collision       = |mask_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Testbench for sprite_compositor using a scoreboard.
// Stimulus pushes the expected pixel and status values into queues.
// A separate monitor pops them and compares them against the DUT outputs.
module tb_sprite_compositor;

  localparam int N  = 4;
  localparam int SZ = 8;
  localparam int CW = 12;
  localparam int KW = 12;
  localparam int LW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic              video_on;
  logic [CW-1:0]     pixel_x, pixel_y;
  logic [KW-1:0]     tile_color;
  logic [N*CW-1:0]   spr_x, spr_y;
  logic [N-1:0]      spr_en;
  logic [N*KW-1:0]   spr_color;
  logic [N*LW-1:0]   spr_row_addr;
  logic [N*SZ-1:0]   rom_row_a = '0;
  logic [N*SZ-1:0]   rom_row_b = '0;
  logic [KW-1:0]     pixel_color_out;
  logic              video_on_out;
  logic              anim_phase;
  logic              collision;
  logic [N-1:0]      collision_mask;

  sprite_compositor #(
    .NUM_SPRITES(N), .SPRITE_SIZE(SZ), .COORD_W(CW), .COLOR_W(KW), .ANIM_DIV(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .tile_color(tile_color),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .spr_color(spr_color),
    .spr_row_addr(spr_row_addr), .rom_row_a(rom_row_a), .rom_row_b(rom_row_b),
    .pixel_color_out(pixel_color_out), .video_on_out(video_on_out),
    .anim_phase(anim_phase), .collision(collision), .collision_mask(collision_mask)
  );

  always #5 clk = ~clk;

  // Synchronous sprite ROMs. Phase A rows are solid.
  // Phase B row r has only column r set (a diagonal).
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      rom_row_a[i*SZ +: SZ] <= 8'hFF;
      rom_row_b[i*SZ +: SZ] <= 8'h01 << spr_row_addr[i*LW +: LW];
    end
  end

  typedef struct {
    logic [KW-1:0] color;
    logic          vo;
    string         name;
  } pix_exp_t;

  typedef struct {
    string        name;
    logic         ph;
    logic         coll;
    logic [N-1:0] mask;
    logic         chk_out;
  } stat_exp_t;

  pix_exp_t  pixq[$];
  stat_exp_t statq[$];
  pix_exp_t  mon_pe;
  stat_exp_t mon_se;
  int        total = 0;
  int        bad = 0;
  logic      issued = 1'b0;
  logic      iss_d1 = 1'b0;
  logic      iss_d2 = 1'b0;
  logic      done = 1'b0;

  // Delay the "pixel issued" marker by the 2-cycle pipeline latency
  always @(posedge clk) begin
    iss_d1 <= issued;
    iss_d2 <= iss_d1;
  end

  // Monitor: compare the DUT outputs against the queued expectations
  always @(negedge clk) begin
    if (iss_d2) begin
      total++;
      if (pixq.size() == 0) begin
        bad++;
        $display("FAIL pix_unexpected: got color=%h vo=%b, want no output", pixel_color_out, video_on_out);
      end else begin
        mon_pe = pixq.pop_front();
        if (pixel_color_out !== mon_pe.color || video_on_out !== mon_pe.vo) begin
          bad++;
          $display("FAIL %s: got color=%h vo=%b, want color=%h vo=%b",
                   mon_pe.name, pixel_color_out, video_on_out, mon_pe.color, mon_pe.vo);
        end else begin
          $display("pix %s: color=%h vo=%b ok", mon_pe.name, pixel_color_out, video_on_out);
        end
      end
    end
    while (statq.size() != 0) begin
      mon_se = statq.pop_front();
      total++;
      if (anim_phase !== mon_se.ph || collision !== mon_se.coll || collision_mask !== mon_se.mask ||
          (mon_se.chk_out && (pixel_color_out !== '0 || video_on_out !== 1'b0))) begin
        bad++;
        $display("FAIL %s: got phase=%b coll=%b mask=%b out=%h vo=%b, want phase=%b coll=%b mask=%b%s",
                 mon_se.name, anim_phase, collision, collision_mask, pixel_color_out, video_on_out,
                 mon_se.ph, mon_se.coll, mon_se.mask, mon_se.chk_out ? " out=000 vo=0" : "");
      end else begin
        $display("stat %s: phase=%b coll=%b mask=%b ok", mon_se.name, anim_phase, collision, collision_mask);
      end
    end
    if (done) begin
      total++;
      if (pixq.size() != 0) begin
        bad++;
        $display("FAIL drain: got %0d pending pixels, want 0", pixq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // One clock step with idle default inputs
  task automatic step();
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    video_on    = 1'b0;
    issued      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_fs();
    step();
    frame_start = 1'b1;
  endtask

  task automatic pix(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic vo,
                     input logic [KW-1:0] tile, input logic [KW-1:0] expc, input string nm);
    pix_exp_t e;
    step();
    pixel_x    = x;
    pixel_y    = y;
    video_on   = vo;
    tile_color = tile;
    issued     = 1'b1;
    e.color = vo ? expc : '0;
    e.vo    = vo;
    e.name  = nm;
    pixq.push_back(e);
  endtask

  // Queue a status check for the current cycle
  task automatic stat(input string nm, input logic ph, input logic coll,
                      input logic [N-1:0] mask, input logic chk_out);
    stat_exp_t s;
    s.name = nm; s.ph = ph; s.coll = coll; s.mask = mask; s.chk_out = chk_out;
    statq.push_back(s);
  endtask

  task automatic set_spr(input int i, input logic [CW-1:0] x, input logic [CW-1:0] y,
                         input logic en, input logic [KW-1:0] c);
    spr_x[i*CW +: CW]     = x;
    spr_y[i*CW +: CW]     = y;
    spr_en[i]             = en;
    spr_color[i*KW +: KW] = c;
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; video_on = 1'b0;
    pixel_x = '0; pixel_y = '0; tile_color = '0;
    spr_x = '0; spr_y = '0; spr_en = '0; spr_color = '0;

    // Reset state
    idle(3);
    stat("reset_state", 1'b0, 1'b0, 4'b0000, 1'b1);
    step(); rst_n = 1'b1;

    // Background only: no sprite is active before the first frame_start
    pix(12'd0, 12'd0, 1'b1, 12'h00F, 12'h00F, "bg_origin");
    stat("phase_after_reset", 1'b0, 1'b0, 4'b0000, 1'b0);
    pix(12'd5, 12'd5, 1'b1, 12'h123, 12'h123, "bg_other");
    idle(2);

    // Sprite 0 at (100,50) with solid rows
    set_spr(0, 12'd100, 12'd50, 1'b1, 12'hFF0);
    pulse_fs();
    pix(12'd100, 12'd50, 1'b1, 12'h00F, 12'hFF0, "s0_topleft");
    pix(12'd108, 12'd50, 1'b1, 12'h0A0, 12'h0A0, "s0_right_out");
    pix(12'd99,  12'd50, 1'b1, 12'h0A0, 12'h0A0, "s0_left_out");
    pix(12'd107, 12'd57, 1'b1, 12'h0A0, 12'hFF0, "s0_botright");
    pix(12'd100, 12'd58, 1'b1, 12'h0A0, 12'h0A0, "s0_below");
    pix(12'd103, 12'd49, 1'b1, 12'h0A0, 12'h0A0, "s0_above");

    // Changing the shadow position has no effect until the next frame_start
    spr_x[0 +: CW] = 12'd200;
    pix(12'd100, 12'd50, 1'b1, 12'h0A0, 12'hFF0, "shadow_held");
    pix(12'd200, 12'd50, 1'b1, 12'h0A0, 12'h0A0, "shadow_not_yet");
    idle(2);

    // Second frame_start: the sprite moves and the phase flips to 1 (diagonal ROM B)
    pulse_fs();
    pix(12'd200, 12'd50, 1'b1, 12'h0A0, 12'hFF0, "moved_phaseb_r0c0");
    stat("phase_1_after_2nd", 1'b1, 1'b0, 4'b0000, 1'b0);
    pix(12'd201, 12'd50, 1'b1, 12'h0A0, 12'h0A0, "phaseb_hole");
    pix(12'd203, 12'd53, 1'b1, 12'h0A0, 12'hFF0, "phaseb_diag");
    pix(12'd100, 12'd50, 1'b1, 12'h0A0, 12'h0A0, "old_pos_gone");
    idle(2);

    // Collision: sprites 0 and 1 overlap, sprite 2 stands apart
    set_spr(0, 12'd40, 12'd40, 1'b1, 12'hFF0);
    set_spr(1, 12'd40, 12'd40, 1'b1, 12'hF00);
    set_spr(2, 12'd60, 12'd40, 1'b1, 12'h0F0);
    pulse_fs();
    pix(12'd40, 12'd40, 1'b1, 12'h00F, 12'hFF0, "overlap_priority");
    stat("coll_clear_start", 1'b1, 1'b0, 4'b0000, 1'b0);
    pix(12'd60, 12'd40, 1'b1, 12'h00F, 12'h0F0, "s2_alone");
    pix(12'd41, 12'd40, 1'b1, 12'h00F, 12'h00F, "overlap_hole");
    stat("coll_not_yet", 1'b1, 1'b0, 4'b0000, 1'b0);
    step();
    stat("coll_set", 1'b1, 1'b1, 4'b0010, 1'b0);
    idle(3);
    stat("coll_sticky", 1'b1, 1'b1, 4'b0010, 1'b0);
    pulse_fs();
    step();
    stat("coll_cleared_phase0", 1'b0, 1'b0, 4'b0000, 1'b0);

    // Right-edge sprite: no wrap to x=0. video_on=0 blanks the output.
    set_spr(0, 12'd0, 12'd0, 1'b0, 12'h000);
    set_spr(1, 12'd0, 12'd0, 1'b0, 12'h000);
    set_spr(2, 12'd0, 12'd0, 1'b0, 12'h000);
    set_spr(3, 12'd4092, 12'd10, 1'b1, 12'h00C);
    pulse_fs();
    pix(12'd4092, 12'd10, 1'b1, 12'h111, 12'h00C, "edge_first_col");
    pix(12'd4095, 12'd17, 1'b1, 12'h111, 12'h00C, "edge_last_col");
    pix(12'd0,    12'd10, 1'b1, 12'h111, 12'h111, "edge_nowrap_x0");
    pix(12'd3,    12'd10, 1'b1, 12'h111, 12'h111, "edge_nowrap_x3");
    pix(12'd4091, 12'd10, 1'b1, 12'h111, 12'h111, "edge_before");
    pix(12'd4093, 12'd12, 1'b0, 12'h111, 12'h000, "video_off_in_sprite");
    idle(2);

    // Phase goes back to 1, then reset returns the phase and the sprite registers to 0
    pulse_fs();
    step();
    stat("phase_before_reset", 1'b1, 1'b0, 4'b0000, 1'b0);
    step(); rst_n = 1'b0;
    idle(2);
    stat("reset_again", 1'b0, 1'b0, 4'b0000, 1'b1);
    step(); rst_n = 1'b1;
    pix(12'd4092, 12'd10, 1'b1, 12'h555, 12'h555, "after_reset_no_sprite");
    idle(3);
    step();
    done = 1'b1;
  end

endmodule
